// File: rtl/oc_dispatch_sched.sv
// oc_dispatch_sched: one-hot ALU/MEM read grants from ready collectors, oldest-first per warp, round-robin across collectors
module oc_dispatch_sched #(
  parameter int NUM_OC = 4,
  parameter int WID_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_OC-1:0]       Alloc_OC,
  input  logic [NUM_OC-1:0]       RDY_OC,
  input  logic [NUM_OC-1:0]       Valid_OC,
  input  logic [NUM_OC-1:0]       IsMem_OC,
  input  logic [NUM_OC*WID_W-1:0] WarpID_OC,
  input  logic                    ALU_Stall,
  input  logic                    MEM_Ready,
  output logic [NUM_OC-1:0]       ALU_Grt_Sched_OC,
  output logic [NUM_OC-1:0]       MEM_Grt_Sched_OC,
  output logic [1:0]              Grt_Valid
);
  localparam int PW = NUM_OC > 1 ? $clog2(NUM_OC) : 1;
  logic [NUM_OC-1:0] older [NUM_OC];
  logic [NUM_OC-1:0] blk, elig, alu_pick, mem_pick;
  logic [PW-1:0] alu_ptr, mem_ptr, alu_nxt, mem_nxt, ai, mi;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NUM_OC);
  endfunction
  always_comb begin
    blk = '0;
    for (int i = 0; i < NUM_OC; i++)
      for (int j = 0; j < NUM_OC; j++)
        blk[i] = blk[i] | (j != i && Valid_OC[j] && older[j][i] &&
                 WarpID_OC[j*WID_W +: WID_W] == WarpID_OC[i*WID_W +: WID_W]);
  end
  assign elig = RDY_OC & Valid_OC & ~ALU_Grt_Sched_OC & ~MEM_Grt_Sched_OC & ~blk;
  always_comb begin
    alu_pick = '0;
    mem_pick = '0;
    alu_nxt = alu_ptr;
    mem_nxt = mem_ptr;
    ai = '0;
    mi = '0;
    for (int k = NUM_OC - 1; k >= 0; k--) begin
      ai = wrap(int'(alu_ptr) + k);
      mi = wrap(int'(mem_ptr) + k);
      if (elig[ai] && !IsMem_OC[ai]) begin
        alu_pick = NUM_OC'(1) << ai;
        alu_nxt = wrap(int'(ai) + 1);
      end
      if (elig[mi] && IsMem_OC[mi]) begin
        mem_pick = NUM_OC'(1) << mi;
        mem_nxt = wrap(int'(mi) + 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_Grt_Sched_OC <= '0;
      MEM_Grt_Sched_OC <= '0;
      alu_ptr <= '0;
      mem_ptr <= '0;
      older <= '{default: '0};
    end else begin
      ALU_Grt_Sched_OC <= ALU_Stall ? '0 : alu_pick;
      MEM_Grt_Sched_OC <= MEM_Ready ? mem_pick : '0;
      if (!ALU_Stall) alu_ptr <= alu_nxt;
      if (MEM_Ready) mem_ptr <= mem_nxt;
      for (int r = 0; r < NUM_OC; r++)
        for (int c = 0; c < NUM_OC; c++)
          older[r][c] <= Alloc_OC[r] ? 1'b0 :
                         (Alloc_OC[c] && Valid_OC[r] && r != c) ? 1'b1 : older[r][c];
    end
  end
  assign Grt_Valid = {|MEM_Grt_Sched_OC, |ALU_Grt_Sched_OC};
endmodule
